npc_gen: RTL and testbench
==========================

Name: npc_gen

Overview:
- Parametrised next-PC generator and PC register for the static MIPS pipeline.
- Generalises pseudo-direct jump address formation ({pc_hi, index, 2'b00}) to configurable widths.
- Adds branch, register-indirect and exception redirects, and a prioritised redirect mux.
- Adds stall handling with a one-entry pending-redirect buffer so no redirect is lost while the front end is frozen.

Parameters:
ADDR_W, 32, PC/address width; must satisfy ADDR_W >= INDEX_W+3
INDEX_W, 26, jump index field width
IMM_W, 16, branch offset field width
RESET_PC, 32'h0000_0000, PC value after reset (lower ADDR_W bits used)
EXC_VEC, 32'h0000_0004, exception entry address

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
stall  in  1  freeze PC (IF/ID stall)
exc_valid  in  1  exception redirect request
jr_valid  in  1  register-indirect jump (JR/JALR) request
jr_target  in  ADDR_W  register operand target
j_valid  in  1  pseudo-direct jump (J/JAL) request
j_index  in  INDEX_W  jump index field
br_valid  in  1  branch instruction resolved this cycle
br_taken  in  1  branch condition true (qualified by br_valid)
br_imm  in  IMM_W  signed branch offset in words
src_pc4  in  ADDR_W  PC+4 of the redirecting instruction
pc  out  ADDR_W  current fetch PC
pc_plus4  out  ADDR_W  pc+4, combinational from pc
redirect  out  1  one-cycle pulse: pc was loaded from a non-sequential source
addr_err  out  1  one-cycle pulse: jr_target misaligned, exception vector taken instead
pending  out  1  a redirect is buffered awaiting stall release

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; redirect=0; addr_err=0; pending=0; buffered target cleared.
- Target formation:
  - Jump: {src_pc4[ADDR_W-1 : INDEX_W+2], j_index, 2'b00}.
  - Branch: src_pc4 + (sign_extend(br_imm) << 2), modulo 2^ADDR_W; wrap-around allowed, no flag.
  - Register jump: jr_target unchanged.
- Request priority: exc_valid > jr_valid > j_valid > (br_valid & br_taken) > sequential.
- Lower-priority requests in the same cycle are discarded.
- Misaligned register jump: jr_valid with jr_target[1:0] != 0 and no exc_valid.
  - Treated as an exception: target=EXC_VEC, addr_err=1 for that update.
- Exceptions ignore stall: pc<=EXC_VEC on the next edge; redirect=1; any pending entry is cleared.
- Non-exception redirect, stall=0, pending=0: pc<=target next edge; redirect=1 for one cycle.
- Non-exception redirect, stall=1: target is latched into the buffer; pending=1; pc holds.
  - If pending is already 1, the new request overwrites the buffer (youngest wins).
- pending=1 and stall=0: pc<=buffered target; redirect=1; pending<=0.
  - A new non-exception request arriving in the same cycle is ignored (buffered redirect is older and wins).
- No request, stall=0, pending=0: pc<=pc+4 (wraps modulo 2^ADDR_W); redirect=0.
- Stall with no request: pc, pending and buffer hold.
- Latency: one clock from request to new pc. Registered outputs are pc, redirect, addr_err, pending; pc_plus4 is combinational.
- br_valid with br_taken=0 is not a redirect and does not disturb pending.

Optional Feature:
Macro NPC_REDIRECT_STATS_EN.
- Defined: adds output redirect_cnt [31:0], a saturating counter (holds at 32'hFFFF_FFFF).
  - Increments on every cycle redirect=1 is asserted.
  - Cleared only by rst_n.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then 4 idle cycles, stall=0 -> pc: 0x0, 0x4, 0x8, 0xC, 0x10; redirect=0 throughout.
- j_valid=1, j_index=26'h0000100, src_pc4=0x4000_0010 -> next pc=0x4000_0400, redirect pulses 1 cycle, then pc=0x4000_0404.
- br_valid=br_taken=1, br_imm=16'hFFFE, src_pc4=0x0000_0020 -> pc=0x0000_0018.
  - Same stimulus with br_taken=0 -> pc+4.
- stall=1 while j_valid (target 0x400), then jr_valid target 0x800 with stall still 1 -> pending=1, pc frozen.
  - Release stall -> pc=0x800, pending=0, redirect=1.
- jr_valid with jr_target=0x0000_1002 -> pc=EXC_VEC (0x4), addr_err=1 and redirect=1 for one cycle.
  - exc_valid with stall=1 and pending=1 -> pc=0x4, pending=0.
- Assert rst_n=0 asynchronously mid-cycle while pending=1 -> pc=RESET_PC and pending=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/npc_gen.sv
// npc_gen: next-PC generator and PC register with prioritised redirects.
// Define NPC_REDIRECT_STATS_EN to add a saturating redirect_cnt output.
module npc_gen #(
  parameter int          ADDR_W   = 32,
  parameter int          INDEX_W  = 26,
  parameter int          IMM_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0004
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              exc_valid,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              j_valid,
  input  logic [INDEX_W-1:0] j_index,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [ADDR_W-1:0] src_pc4,
`ifdef NPC_REDIRECT_STATS_EN
  output logic [31:0]       redirect_cnt,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              addr_err,
  output logic              pending
);

  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] EXC_A = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);

  logic              jr_bad;
  logic              exc_req;
  logic              jr_ok;
  logic              j_sel;
  logic              br_sel;
  logic              req;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pbuf;

  assign pc_plus4 = pc + FOUR;

  // One-hot request selects; lower priorities are masked off here.
  assign jr_bad  = jr_valid & ~exc_valid & (jr_target[1:0] != 2'b00);
  assign exc_req = exc_valid | jr_bad;
  assign jr_ok   = jr_valid & ~exc_valid & (jr_target[1:0] == 2'b00);
  assign j_sel   = j_valid & ~exc_valid & ~jr_valid;
  assign br_sel  = br_valid & br_taken & ~exc_valid
                 & ~jr_valid & ~j_valid;
  assign req     = jr_ok | j_sel | br_sel;

  assign br_off = {{(ADDR_W-IMM_W-2){br_imm[IMM_W-1]}},
                   br_imm, 2'b00};

  always_comb begin
    tgt = '0;
    unique case (1'b1)
      jr_ok:   tgt = jr_target;
      j_sel:   tgt = {src_pc4[ADDR_W-1:INDEX_W+2],
                      j_index, 2'b00};
      br_sel:  tgt = src_pc4 + br_off;
      default: tgt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RST_A;
      redirect <= 1'b0;
      addr_err <= 1'b0;
      pending  <= 1'b0;
      pbuf     <= '0;
    end else begin
      redirect <= 1'b0;
      addr_err <= 1'b0;
      if (exc_req) begin
        pc       <= EXC_A;
        redirect <= 1'b1;
        addr_err <= jr_bad;
        pending  <= 1'b0;
      end else if (pending && !stall) begin
        pc       <= pbuf;
        redirect <= 1'b1;
        pending  <= 1'b0;
      end else if (req && stall) begin
        pbuf    <= tgt;
        pending <= 1'b1;
      end else if (req) begin
        pc       <= tgt;
        redirect <= 1'b1;
      end else if (!stall) begin
        pc <= pc_plus4;
      end
    end
  end

`ifdef NPC_REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (redirect && redirect_cnt != 32'hFFFF_FFFF) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_gen.sv
// tb_npc_gen: directed plus random stimulus against a behavioural
// next-PC model; compares every registered output after each edge.
module tb_npc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc_valid, jr_valid, j_valid;
  logic        br_valid, br_taken;
  logic [31:0] jr_target, src_pc4;
  logic [25:0] j_index;
  logic [15:0] br_imm;
  logic [31:0] pc, pc_plus4;
  logic        redirect, addr_err, pending;
`ifdef NPC_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_buf, m_cnt;
  logic        m_red, m_aerr, m_pend;

  always #5 clk = ~clk;

  npc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .exc_valid(exc_valid), .jr_valid(jr_valid),
    .jr_target(jr_target), .j_valid(j_valid),
    .j_index(j_index), .br_valid(br_valid),
    .br_taken(br_taken), .br_imm(br_imm),
    .src_pc4(src_pc4),
`ifdef NPC_REDIRECT_STATS_EN
    .redirect_cnt(redirect_cnt),
`endif
    .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
    .addr_err(addr_err), .pending(pending)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 0; exc_valid = 0; jr_valid = 0; j_valid = 0;
    br_valid = 0; br_taken = 0; jr_target = 0;
    j_index = 0; br_imm = 0; src_pc4 = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_buf = 0; m_cnt = 0;
    m_red = 0; m_aerr = 0; m_pend = 0;
  endtask

  // Next state from the redirect rules, using plain address arithmetic.
  task automatic model_step();
    logic [31:0] t;
    logic        has;
    has = 1;
    if (jr_valid)               t = jr_target;
    else if (j_valid)           t = (src_pc4 & 32'hF000_0000)
                                  + {4'h0, j_index, 2'b00};
    else if (br_valid && br_taken)
      t = src_pc4 + 32'(int'($signed(br_imm)) * 4);
    else begin t = 0; has = 0; end
    if (m_red) m_cnt = m_cnt + 1;
    m_aerr = 0;
    m_red  = 0;
    if (exc_valid || (jr_valid && (jr_target % 4) != 0)) begin
      m_pc = 32'h4; m_red = 1; m_pend = 0;
      m_aerr = !exc_valid;
    end else if (m_pend && !stall) begin
      m_pc = m_buf; m_red = 1; m_pend = 0;
    end else if (has && stall) begin
      m_buf = t; m_pend = 1;
    end else if (has) begin
      m_pc = t; m_red = 1;
    end else if (!stall) begin
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
    check({tag, ".redir"}, {31'b0, redirect}, {31'b0, m_red});
    check({tag, ".aerr"}, {31'b0, addr_err}, {31'b0, m_aerr});
    check({tag, ".pend"}, {31'b0, pending}, {31'b0, m_pend});
`ifdef NPC_REDIRECT_STATS_EN
    check({tag, ".cnt"}, redirect_cnt, m_cnt);
`endif
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    compare_all("rst");
    check("rst_pc_const", pc, 32'h0);

    for (int i = 0; i < 4; i++) cycle("seq");
    check("seq_pc_const", pc, 32'h10);

    j_valid = 1; j_index = 26'h0000100; src_pc4 = 32'h4000_0010;
    cycle("jump");
    check("jump_const", pc, 32'h4000_0400);
    cycle("jump_next");
    check("jump_next_const", pc, 32'h4000_0404);

    br_valid = 1; br_taken = 1; br_imm = 16'hFFFE;
    src_pc4 = 32'h20;
    cycle("br_t");
    check("br_t_const", pc, 32'h18);
    br_valid = 1; br_taken = 0; br_imm = 16'hFFFE;
    src_pc4 = 32'h20;
    cycle("br_nt");
    check("br_nt_const", pc, 32'h1C);

    stall = 1; j_valid = 1; j_index = 26'h100; src_pc4 = 0;
    cycle("stall_j");
    stall = 1; jr_valid = 1; jr_target = 32'h800;
    cycle("stall_jr");
    check("stall_pc_const", pc, 32'h1C);
    stall = 0; j_valid = 1; j_index = 26'h3;
    cycle("release");
    check("release_const", pc, 32'h800);

    jr_valid = 1; jr_target = 32'h0000_1002;
    cycle("jr_mis");
    check("jr_mis_aerr", {31'b0, addr_err}, 32'h1);
    cycle("jr_mis_after");

    stall = 1; br_valid = 1; br_taken = 1; br_imm = 16'h10;
    src_pc4 = 32'h100;
    cycle("pend_br");
    stall = 1; exc_valid = 1;
    cycle("exc_stall");
    check("exc_pend_const", {31'b0, pending}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(0, 99) < 35);
      exc_valid = ($urandom_range(0, 99) < 5);
      jr_valid  = ($urandom_range(0, 99) < 12);
      jr_target = $urandom;
      if ($urandom_range(0, 3) != 0) jr_target[1:0] = 2'b00;
      j_valid   = ($urandom_range(0, 99) < 15);
      j_index   = 26'($urandom);
      br_valid  = ($urandom_range(0, 99) < 25);
      br_taken  = $urandom_range(0, 1) == 1;
      br_imm    = 16'($urandom);
      src_pc4   = $urandom;
      cycle("rand");
    end

    stall = 1; j_valid = 1; j_index = 26'h55; src_pc4 = 0;
    cycle("pre_arst");
    check("pre_arst_pend", {31'b0, pending}, 32'h1);
    #3 rst_n = 0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_pend", {31'b0, pending}, 32'h0);
    check("arst_redir", {31'b0, redirect}, 32'h0);
    #2 rst_n = 1;
    model_reset();
    idle();
    cycle("post_arst");
    cycle("post_arst2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
